uart_baud_gen_frac: RTL and testbench
=====================================

Name: uart_baud_gen_frac

Overview:
Fractional baud-rate generator for the UART TX/RX engines.
- Produces an oversample tick (os_tick), a bit tick (bit_tick) and a mid-bit sample tick (mid_tick).
- Effective oversample period is divisor_int + divisor_frac/2^FRAC_W clocks.
- Divisor writes are double-buffered and applied glitch-free. The RX path can re-phase the generator on a start-bit edge via resync.

Parameters:
INT_W, 16, width of integer divisor and period counter
FRAC_W, 4, width of fractional divisor / accumulator
OVERSAMPLE, 16, os_ticks per bit; power of two, >= 4

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run when 1; clear and hold all state when 0
divisor_int  in  INT_W  integer part of oversample period (clocks)
divisor_frac  in  FRAC_W  fractional part, units of 2^-FRAC_W clock
div_load  in  1  one-cycle strobe; capture divisor_int/divisor_frac into the pending shadow
resync  in  1  one-cycle strobe; restart phase from zero
os_tick  out  1  one-cycle pulse per oversample period
bit_tick  out  1  one-cycle pulse every OVERSAMPLE os_ticks
mid_tick  out  1  one-cycle pulse at bit centre
cfg_err  out  1  active divisor_int == 0
load_pending  out  1  shadow captured but not yet applied

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - all outputs 0
  - cnt, acc, extra, os_cnt all 0
  - active divisor = 1 + 0/2^FRAC_W
- Shadow/active divisor registers:
  - div_load latches the inputs into the shadow and sets load_pending.
  - Shadow copies to active at the next os period boundary (edge on which os_tick is set), or on the next edge if enable=0.
  - Copying clears load_pending.
  - div_load coinciding with the apply edge: the new value goes to the shadow, load_pending stays 1.
  - Reset clears load_pending.
- Period length L = max(divisor_int_active, 1) + extra.
  - cfg_err = (divisor_int_active == 0), registered. A zero divisor behaves as 1.
- cnt increments each enabled edge.
  - On the edge where cnt == L-1: cnt <= 0, os_tick <= 1, and {carry, acc} <= acc + frac_active (FRAC_W+1-bit add), extra <= carry.
  - Otherwise os_tick <= 0.
- Latency: first os_tick is high after the L-th rising edge at which enable=1 is sampled.
  - Example: divisor 3, frac 8, periods are 3,3,4,3,4,...
- os_cnt (log2 OVERSAMPLE bits) increments on each os boundary and wraps to 0.
  - bit_tick set on the boundary where os_cnt == OVERSAMPLE-1.
  - mid_tick set on the boundary where os_cnt == OVERSAMPLE/2-1.
  - All three ticks are registered and asserted in the same cycle as the corresponding os_tick.
- enable=0: on the next edge, cnt, acc, extra, os_cnt clear and all tick outputs drop to 0. The shadow is still honoured.
- resync (enable=1): on the next edge, cnt, acc, extra, os_cnt clear and all tick outputs are 0.
  - resync has priority over a coincident boundary; that tick is suppressed and its pending apply is deferred.
  - After resync the first mid_tick occurs after exactly OVERSAMPLE/2 periods.
- Counter arithmetic is INT_W+1 bits internally so L = 2^INT_W-1 + 1 cannot overflow.
- A divisor change never truncates or extends the period in progress.

Decomposition:
- uart_pkg holds:
  - UART_OVERSAMPLE_DEFAULT
  - UART_DIV_INT_W / UART_DIV_FRAC_W defaults
  - a struct/typedef for {divisor_int, divisor_frac} shared with the register block
- One natural sub-module, uart_baud_frac_acc: the accumulator and extra-carry flop, stepped by the boundary strobe and cleared by resync/!enable.

Test Plan:
- Reset then enable with divisor 3/0 (load while disabled): os_tick after edges 3,6,9,...; bit_tick after edge 48; mid_tick after edge 24; cfg_err=0.
- Divisor 3/8, FRAC_W=4: os periods 3,3,4,3,4,...; first bit_tick after edge 55; 16 further bit periods average 56 clocks.
- Divisor 0/0: os_tick every cycle, cfg_err=1. Load 5/0 mid-run: cfg_err drops after the next boundary, then period 5.
- Divisor 10/0 running, div_load 4/0 at cnt=2: current period still 10, load_pending=1 until that boundary, then periods of 4.
- resync asserted in the same cycle a boundary would fire: no os_tick, cnt restarts. mid_tick appears exactly 8 periods later, bit_tick 16 periods later.
- enable drop mid-period, or rst_n asserted asynchronously mid-period: all ticks 0 immediately (reset) or next edge (enable). Re-enable: first os_tick after L edges with acc=0.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared definitions: divisor defaults and the divisor
// bundle shared between the register block and the baud generator.
package uart_pkg;

  localparam int UART_OVERSAMPLE_DEFAULT = 16;
  localparam int UART_DIV_INT_W          = 16;
  localparam int UART_DIV_FRAC_W         = 4;

  typedef struct packed {
    logic [UART_DIV_INT_W-1:0]  div_int;
    logic [UART_DIV_FRAC_W-1:0] div_frac;
  } uart_div_t;

  function automatic uart_div_t uart_div_mk(
    input logic [UART_DIV_INT_W-1:0]  i,
    input logic [UART_DIV_FRAC_W-1:0] f
  );
    uart_div_t d;
    d.div_int  = i;
    d.div_frac = f;
    return d;
  endfunction

endpackage

// File: rtl/uart_baud_frac_acc.sv
// Fractional phase accumulator for the baud generator.
// Overflow of acc + frac lengthens the following period by one clock.
module uart_baud_frac_acc
  import uart_pkg::*;
#(
  parameter int FRAC_W = UART_DIV_FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              step_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              extra_o
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              extra_q, extra_d;
  logic [FRAC_W:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, frac_i};

  // Step on each period boundary; clear wins over step.
  always_comb begin
    acc_d   = acc_q;
    extra_d = extra_q;
    if (clr_i) begin
      acc_d   = '0;
      extra_d = 1'b0;
    end else if (step_i) begin
      acc_d   = sum[FRAC_W-1:0];
      extra_d = sum[FRAC_W];
    end
  end

  // Accumulator and carry-out state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      extra_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      extra_q <= extra_d;
    end
  end

  assign extra_o = extra_q;

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud generator: oversample, mid-bit and bit ticks
// with a double-buffered divisor applied on period boundaries.
module uart_baud_gen_frac
  import uart_pkg::*;
#(
  parameter int INT_W      = UART_DIV_INT_W,
  parameter int FRAC_W     = UART_DIV_FRAC_W,
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [INT_W-1:0]  divisor_int,
  input  logic [FRAC_W-1:0] divisor_frac,
  input  logic              div_load,
  input  logic              resync,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              mid_tick,
  output logic              cfg_err,
  output logic              load_pending
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [INT_W:0]  CNT_ONE = {{INT_W{1'b0}}, 1'b1};
  localparam logic [INT_W-1:0] INT_ONE = {{(INT_W-1){1'b0}}, 1'b1};
  localparam logic [OS_W-1:0] OS_ONE  = {{(OS_W-1){1'b0}}, 1'b1};
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [INT_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [INT_W-1:0]  sh_int_q, sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic              pend_q, pend_d;
  logic [INT_W:0]    cnt_q, cnt_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic              os_q, os_d;
  logic              bit_q, bit_d;
  logic              mid_q, mid_d;
  logic              err_q, err_d;

  logic              clr;
  logic              bnd;
  logic              apply;
  logic              extra;
  logic [INT_W-1:0]  int_eff;
  logic [INT_W:0]    per_len;

  assign clr     = !enable || resync;
  assign int_eff = (act_int_q == '0) ? INT_ONE : act_int_q;
  assign per_len = {1'b0, int_eff} + {{INT_W{1'b0}}, extra};
  assign bnd     = !clr && (cnt_q == per_len - CNT_ONE);
  assign apply   = pend_q && (bnd || !enable);

  uart_baud_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .step_i  (bnd),
    .frac_i  (act_frac_q),
    .extra_o (extra)
  );

  // Period and oversample counters plus tick generation.
  always_comb begin
    cnt_d    = cnt_q + CNT_ONE;
    os_cnt_d = os_cnt_q;
    if (clr) begin
      cnt_d    = '0;
      os_cnt_d = '0;
    end else if (bnd) begin
      cnt_d    = '0;
      os_cnt_d = os_cnt_q + OS_ONE;
    end
    os_d  = bnd;
    bit_d = bnd && (os_cnt_q == OS_LAST);
    mid_d = bnd && (os_cnt_q == OS_MID);
  end

  // Shadow capture and boundary-aligned apply of the divisor.
  always_comb begin
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    pend_d     = pend_q && !apply;
    if (apply) begin
      act_int_d  = sh_int_q;
      act_frac_d = sh_frac_q;
    end
    if (div_load) begin
      sh_int_d  = divisor_int;
      sh_frac_d = divisor_frac;
      pend_d    = 1'b1;
    end
    err_d = (act_int_d == '0);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_int_q  <= INT_ONE;
      act_frac_q <= '0;
      sh_int_q   <= '0;
      sh_frac_q  <= '0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      os_cnt_q   <= '0;
      os_q       <= 1'b0;
      bit_q      <= 1'b0;
      mid_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      os_cnt_q   <= os_cnt_d;
      os_q       <= os_d;
      bit_q      <= bit_d;
      mid_q      <= mid_d;
      err_q      <= err_d;
    end
  end

  assign os_tick      = os_q;
  assign bit_tick     = bit_q;
  assign mid_tick     = mid_q;
  assign cfg_err      = err_q;
  assign load_pending = pend_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: cycle scoreboard against a
// remaining-clocks model, plus directed tick-position checks.
module tb_uart_baud_gen_frac;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] divisor_int = '0;
  logic [3:0]  divisor_frac = '0;
  logic        div_load = 1'b0;
  logic        resync = 1'b0;
  logic        os_tick, bit_tick, mid_tick, cfg_err, load_pending;

  uart_baud_gen_frac #(
    .INT_W      (16),
    .FRAC_W     (4),
    .OVERSAMPLE (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .divisor_int  (divisor_int),
    .divisor_frac (divisor_frac),
    .div_load     (div_load),
    .resync       (resync),
    .os_tick      (os_tick),
    .bit_tick     (bit_tick),
    .mid_tick     (mid_tick),
    .cfg_err      (cfg_err),
    .load_pending (load_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic os;
    logic bt;
    logic mid;
    logic err;
    logic pend;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   edge_n = 0;
  int   os_e[$];
  int   bit_e[$];
  int   mid_e[$];

  int m_int, m_frac, s_int, s_frac;
  int m_acc, m_extra, m_os, m_rem;
  bit m_pend;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int at(input int k, input int i);
    if (k == 0 && i < os_e.size())  return os_e[i];
    if (k == 1 && i < bit_e.size()) return bit_e[i];
    if (k == 2 && i < mid_e.size()) return mid_e[i];
    return -1;
  endfunction

  task automatic model_reset();
    m_int = 1; m_frac = 0; s_int = 0; s_frac = 0;
    m_acc = 0; m_extra = 0; m_os = 0; m_rem = 0;
    m_pend = 0;
    sb.delete();
  endtask

  task automatic model_step();
    exp_t e;
    bit   bnd;
    int   sum;
    bnd = 0;
    if (enable && !resync) begin
      if (m_rem == 0)
        m_rem = ((m_int == 0) ? 1 : m_int) + m_extra;
      m_rem--;
      bnd = (m_rem == 0);
    end else begin
      m_rem = 0;
    end
    e.os  = bnd;
    e.bt  = bnd && (m_os == 15);
    e.mid = bnd && (m_os == 7);
    if (bnd) begin
      sum     = m_acc + m_frac;
      m_extra = sum / 16;
      m_acc   = sum % 16;
      m_os    = (m_os + 1) % 16;
    end
    if (!enable || resync) begin
      m_acc = 0; m_extra = 0; m_os = 0;
    end
    if (m_pend && (bnd || !enable)) begin
      m_int  = s_int;
      m_frac = s_frac;
      m_pend = 0;
    end
    if (div_load) begin
      s_int  = int'(divisor_int);
      s_frac = int'(divisor_frac);
      m_pend = 1;
    end
    e.err  = (m_int == 0);
    e.pend = m_pend;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t x;
    @(posedge clk);
    model_step();
    @(negedge clk);
    edge_n++;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      x = sb.pop_front();
      chk("os_tick", int'(os_tick), int'(x.os));
      chk("bit_tick", int'(bit_tick), int'(x.bt));
      chk("mid_tick", int'(mid_tick), int'(x.mid));
      chk("cfg_err", int'(cfg_err), int'(x.err));
      chk("load_pending", int'(load_pending), int'(x.pend));
    end
    if (os_tick)  os_e.push_back(edge_n);
    if (bit_tick) bit_e.push_back(edge_n);
    if (mid_tick) mid_e.push_back(edge_n);
    div_load = 1'b0;
    resync   = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mark();
    edge_n = 0;
    os_e.delete();
    bit_e.delete();
    mid_e.delete();
  endtask

  task automatic load(input uart_div_t d);
    divisor_int  = d.div_int;
    divisor_frac = d.div_frac;
    div_load     = 1'b1;
  endtask

  task automatic load_idle(input uart_div_t d);
    enable = 1'b0;
    load(d);
    run(2);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_os", int'(os_tick), 0);
    chk("rst_bit", int'(bit_tick), 0);
    chk("rst_mid", int'(mid_tick), 0);
    chk("rst_err", int'(cfg_err), 0);
    chk("rst_pend", int'(load_pending), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Integer divisor 3
    load_idle(uart_div_mk(16'd3, 4'd0));
    mark();
    enable = 1'b1;
    run(60);
    chk("t1_os0", at(0, 0), 3);
    chk("t1_os1", at(0, 1), 6);
    chk("t1_os2", at(0, 2), 9);
    chk("t1_mid0", at(2, 0), 24);
    chk("t1_bit0", at(1, 0), 48);

    // Fractional divisor 3 + 8/16
    load_idle(uart_div_mk(16'd3, 4'd8));
    mark();
    enable = 1'b1;
    run(960);
    chk("t2_os0", at(0, 0), 3);
    chk("t2_os1", at(0, 1), 6);
    chk("t2_os2", at(0, 2), 10);
    chk("t2_os3", at(0, 3), 13);
    chk("t2_os4", at(0, 4), 17);
    chk("t2_bit0", at(1, 0), 55);
    chk("t2_bit16", at(1, 16) - at(1, 0), 896);

    // Zero divisor, then live reload to 5
    load_idle(uart_div_mk(16'd0, 4'd0));
    chk("t3_err", int'(cfg_err), 1);
    mark();
    enable = 1'b1;
    run(4);
    chk("t3_every", at(0, 3), 4);
    load(uart_div_mk(16'd5, 4'd0));
    mark();
    run(12);
    chk("t3_os1", at(0, 1), 2);
    chk("t3_os2", at(0, 2), 7);
    chk("t3_err_clr", int'(cfg_err), 0);

    // Reload mid-period does not disturb the running period
    load_idle(uart_div_mk(16'd10, 4'd0));
    mark();
    enable = 1'b1;
    run(12);
    load(uart_div_mk(16'd4, 4'd0));
    step();
    chk("t4_pend", int'(load_pending), 1);
    run(17);
    chk("t4_os0", at(0, 0), 10);
    chk("t4_os1", at(0, 1), 20);
    chk("t4_os2", at(0, 2), 24);
    chk("t4_os3", at(0, 3), 28);

    // Resync on the would-be boundary edge
    for (int i = 0; i < 10 && m_rem != 1; i++) step();
    resync = 1'b1;
    mark();
    step();
    chk("t5_sup", int'(os_tick), 0);
    run(70);
    chk("t5_os0", at(0, 0), 5);
    chk("t5_mid0", at(2, 0), 33);
    chk("t5_bit0", at(1, 0), 65);

    // Enable drop clears the accumulator
    load_idle(uart_div_mk(16'd3, 4'd8));
    enable = 1'b1;
    run(11);
    enable = 1'b0;
    step();
    chk("t6_off", int'(os_tick), 0);
    mark();
    enable = 1'b1;
    run(12);
    chk("t6_os0", at(0, 0), 3);
    chk("t6_os1", at(0, 1), 6);
    chk("t6_os2", at(0, 2), 10);

    // Asynchronous reset mid-run
    load_idle(uart_div_mk(16'd0, 4'd0));
    enable = 1'b1;
    run(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_os", int'(os_tick), 0);
    chk("ar_err", int'(cfg_err), 0);
    chk("ar_bit", int'(bit_tick), 0);
    chk("ar_mid", int'(mid_tick), 0);
    chk("ar_pend", int'(load_pending), 0);
    model_reset();
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mark();
    enable = 1'b1;
    run(3);
    chk("ar_os0", at(0, 0), 1);
    chk("ar_os1", at(0, 1), 2);

    // Random traffic against the scoreboard
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 11) == 0)
        load(uart_div_mk(16'($urandom_range(0, 6)),
                         4'($urandom_range(0, 15))));
      if ($urandom_range(0, 24) == 0)
        resync = 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
